cpu6_bus_responder: RTL and testbench



---
 rtl/cpu6_bus_pkg.sv | 32 +++
 rtl/mux_uart_tx.sv | 128 ++++++++++++
 rtl/cpu6_bus_responder.sv | 137 +++++++++++++
 tb/tb_cpu6_bus_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu6_bus_pkg.sv
// Shared definitions for the CPU6 bus responder: console register map,
// status bit positions and the serializer state encoding.
package cpu6_bus_pkg;

   localparam logic [15:0] MUX_BASE_DEFAULT = 16'hF200;

   localparam int STAT_RXRDY = 0;
   localparam int STAT_TXNF  = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_OVF   = 7;

   localparam logic [7:0] UNMAPPED_READ = 8'hFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } ser_state_e;

   // Console status byte; the port is transmit-only, so rx-ready reads as zero.
   function automatic logic [7:0] status_byte(input logic txnf, input logic busy, input logic ovf);
      logic [7:0] s;
      s             = 8'h00;
      s[STAT_RXRDY] = 1'b0;
      s[STAT_TXNF]  = txnf;
      s[STAT_BUSY]  = busy;
      s[STAT_OVF]   = ovf;
      return s;
   endfunction

endpackage

// File: rtl/mux_uart_tx.sv
// 8N1 LSB-first serializer for the MUX console. Pulls bytes from the TX FIFO
// and chains frames back to back when more data is waiting at the stop bit.
module mux_uart_tx
   import cpu6_bus_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
)(
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] tx_byte,
   input  logic       tx_valid,
   output logic       tx_pop,
   output logic       tx,
   output logic       busy
);

   localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1'b1);

   ser_state_e        state_r, state_s;
   logic [BAUD_W-1:0] baud_r, baud_s;
   logic [2:0]        bit_r, bit_s;
   logic [7:0]        shift_r, shift_s;
   logic              tx_r, tx_s;
   logic              busy_r;
   logic              pop_s;
   logic              bit_end_s;

   // Next-state, pop request and next line level for the serializer.
   always_comb begin
      state_s   = state_r;
      baud_s    = baud_r;
      bit_s     = bit_r;
      shift_s   = shift_r;
      tx_s      = tx_r;
      pop_s     = 1'b0;
      bit_end_s = (baud_r == BAUD_LAST);
      case (state_r)
         IDLE: begin
            if (tx_valid) begin
               pop_s   = 1'b1;
               shift_s = tx_byte;
               state_s = START;
               baud_s  = BAUD_ZERO;
               bit_s   = 3'd0;
               tx_s    = 1'b0;
            end else begin
               tx_s    = 1'b1;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_s = DATA;
               baud_s  = BAUD_ZERO;
               bit_s   = 3'd0;
               tx_s    = shift_r[0];
            end else begin
               baud_s  = baud_r + BAUD_ONE;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               baud_s = BAUD_ZERO;
               if (bit_r == 3'd7) begin
                  state_s = STOP;
                  tx_s    = 1'b1;
               end else begin
                  bit_s   = bit_r + 3'd1;
                  shift_s = {1'b0, shift_r[7:1]};
                  tx_s    = shift_r[1];
               end
            end else begin
               baud_s = baud_r + BAUD_ONE;
            end
         end
         STOP: begin
            if (bit_end_s) begin
               baud_s = BAUD_ZERO;
               bit_s  = 3'd0;
               // Chain straight into the next start bit when data is queued.
               if (tx_valid) begin
                  pop_s   = 1'b1;
                  shift_s = tx_byte;
                  state_s = START;
                  tx_s    = 1'b0;
               end else begin
                  state_s = IDLE;
                  tx_s    = 1'b1;
               end
            end else begin
               baud_s = baud_r + BAUD_ONE;
            end
         end
         default: begin
            state_s = IDLE;
            baud_s  = BAUD_ZERO;
            bit_s   = 3'd0;
            tx_s    = 1'b1;
         end
      endcase
   end

   // Serializer state registers; reset aborts any frame in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
         baud_r  <= BAUD_ZERO;
         bit_r   <= 3'd0;
         shift_r <= 8'h00;
         tx_r    <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         baud_r  <= baud_s;
         bit_r   <= bit_s;
         shift_r <= shift_s;
         tx_r    <= tx_s;
         busy_r  <= (state_s != IDLE);
      end
   end

   assign tx_pop = pop_s;
   assign tx     = tx_r;
   assign busy   = busy_r;

endmodule

// File: rtl/cpu6_bus_responder.sv
// CPU6 bus slave: byte RAM at 0x0000, MUX console status/data registers with
// a TX FIFO feeding the serializer, and 0xFF for every unmapped read.
module cpu6_bus_responder
   import cpu6_bus_pkg::*;
#(
   parameter int          RAM_ADDR_BITS = 12,
   parameter logic [15:0] MUX_BASE      = MUX_BASE_DEFAULT,
   parameter int          CLKS_PER_BIT  = 16,
   parameter int          FIFO_DEPTH    = 4
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] addressBus,
   input  logic [7:0]  dataOutBus,
   input  logic        writeEnBus,
   output logic [7:0]  dataInBus,
   output logic        tx,
   output logic        tx_busy
);

   localparam int                 RAM_WORDS = 2**RAM_ADDR_BITS;
   localparam int                 PTR_W     = $clog2(FIFO_DEPTH);
   localparam int                 CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam logic [15:0]        MUX_DATA  = MUX_BASE + 16'd1;
   localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1'b1);
   localparam logic [PTR_W-1:0]   PTR_ZERO  = {PTR_W{1'b0}};

   logic [7:0]               ram_r [RAM_WORDS];
   logic [7:0]               fifo_r [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0]         count_r;
   logic                     ovf_r;
   logic [7:0]               data_in_r;

   logic [RAM_ADDR_BITS-1:0] ram_addr_s;
   logic                     is_ram_s, is_stat_s, is_data_s;
   logic                     fifo_full_s, push_req_s, push_ok_s, ovf_set_s;
   logic                     pop_s, ser_busy_s, ser_tx_s;
   logic [7:0]               rd_data_s;

   // Address decode and FIFO push/overflow qualification.
   always_comb begin
      ram_addr_s  = addressBus[RAM_ADDR_BITS-1:0];
      is_ram_s    = ((addressBus >> RAM_ADDR_BITS) == 16'd0);
      is_stat_s   = (addressBus == MUX_BASE);
      is_data_s   = (addressBus == MUX_DATA);
      fifo_full_s = (count_r == CNT_FULL);
      push_req_s  = writeEnBus & is_data_s;
      // A pop on the same edge frees a slot, so a full FIFO still accepts.
      push_ok_s   = push_req_s & (~fifo_full_s | pop_s);
      ovf_set_s   = push_req_s & fifo_full_s & ~pop_s;
   end

   // Read data mux; a RAM write forwards its data to the same-edge read.
   always_comb begin
      rd_data_s = UNMAPPED_READ;
      if (is_ram_s) begin
         if (writeEnBus) begin
            rd_data_s = dataOutBus;
         end else begin
            rd_data_s = ram_r[ram_addr_s];
         end
      end else if (is_stat_s) begin
         rd_data_s = status_byte(~fifo_full_s, tx_busy, ovf_r);
      end else if (is_data_s) begin
         rd_data_s = 8'h00;
      end else begin
         rd_data_s = UNMAPPED_READ;
      end
   end

   // RAM storage; deliberately not cleared by reset.
   always_ff @(posedge clock) begin
      if (writeEnBus && is_ram_s) begin
         ram_r[ram_addr_s] <= dataOutBus;
      end
   end

   // FIFO storage array.
   always_ff @(posedge clock) begin
      if (push_ok_s) begin
         fifo_r[wr_ptr_r] <= dataOutBus;
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
         ovf_r    <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_s);
         // Setting beats the clear-on-status-read when both land together.
         if (ovf_set_s) begin
            ovf_r <= 1'b1;
         end else if (is_stat_s) begin
            ovf_r <= 1'b0;
         end
      end
   end

   // Registered read data returned to the core.
   always_ff @(posedge clock) begin
      if (reset) begin
         data_in_r <= 8'h00;
      end else begin
         data_in_r <= rd_data_s;
      end
   end

   mux_uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_tx (
      .clock    (clock),
      .reset    (reset),
      .tx_byte  (fifo_r[rd_ptr_r]),
      .tx_valid (count_r != CNT_ZERO),
      .tx_pop   (pop_s),
      .tx       (ser_tx_s),
      .busy     (ser_busy_s)
   );

   assign dataInBus = data_in_r;
   assign tx        = ser_tx_s;
   assign tx_busy   = ser_busy_s | (count_r != CNT_ZERO);

endmodule

// File: tb/tb_cpu6_bus_responder.sv
// Directed bench for cpu6_bus_responder with a 4-cycle bit time.
module tb_cpu6_bus_responder;

   logic        clock;
   logic        reset;
   logic [15:0] addressBus;
   logic [7:0]  dataOutBus;
   logic        writeEnBus;
   logic [7:0]  dataInBus;
   logic        tx;
   logic        tx_busy;

   int checks;
   int passes;

   localparam logic [15:0] IDLE_ADDR = 16'h8000;
   localparam logic [15:0] STAT_ADDR = 16'hF200;
   localparam logic [15:0] DATA_ADDR = 16'hF201;

   cpu6_bus_responder #(
      .RAM_ADDR_BITS (12),
      .MUX_BASE      (16'hF200),
      .CLKS_PER_BIT  (4),
      .FIFO_DEPTH    (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .addressBus (addressBus),
      .dataOutBus (dataOutBus),
      .writeEnBus (writeEnBus),
      .dataInBus  (dataInBus),
      .tx         (tx),
      .tx_busy    (tx_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected line level k cycles into a frame of byte b (4 cycles per bit).
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      int idx;
      idx = k / 4;
      if (idx == 0) return 1'b0;
      else if (idx == 9) return 1'b1;
      else return b[idx-1];
   endfunction

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      addressBus = a; dataOutBus = d; writeEnBus = 1'b1;
      @(negedge clock);
      writeEnBus = 1'b0; addressBus = IDLE_ADDR;
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] q);
      addressBus = a; writeEnBus = 1'b0;
      @(negedge clock);
      q = dataInBus;
      addressBus = IDLE_ADDR;
   endtask

   task automatic test_reset();
      logic [7:0] q;
      reset = 1'b1; addressBus = IDLE_ADDR; dataOutBus = 8'h00; writeEnBus = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (dataInBus !== 8'h00) $display("FAIL reset_data: got %h exp 00", dataInBus); else passes++;
      checks++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b exp 1", tx); else passes++;
      checks++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b exp 0", tx_busy); else passes++;
      reset = 1'b0;
      rd(STAT_ADDR, q);
      checks++; if (q !== 8'h02) $display("FAIL reset_status: got %h exp 02", q); else passes++;
   endtask

   task automatic test_ram();
      logic [7:0] q;
      wr(16'h0123, 8'h5A);
      rd(16'h0123, q);
      checks++; if (q !== 8'h5A) $display("FAIL ram_0123: got %h exp 5a", q); else passes++;
      wr(16'h0FFF, 8'hA5);
      rd(16'h0FFF, q);
      checks++; if (q !== 8'hA5) $display("FAIL ram_top: got %h exp a5", q); else passes++;
      rd(16'h0123, q);
      checks++; if (q !== 8'h5A) $display("FAIL ram_keep: got %h exp 5a", q); else passes++;
   endtask

   task automatic test_decode();
      logic [7:0] q;
      rd(16'h8000, q);
      checks++; if (q !== 8'hFF) $display("FAIL unmapped_8000: got %h exp ff", q); else passes++;
      rd(16'h1000, q);
      checks++; if (q !== 8'hFF) $display("FAIL unmapped_1000: got %h exp ff", q); else passes++;
      wr(16'h0000, 8'h3C);
      wr(16'h8000, 8'h77);
      rd(16'h0000, q);
      checks++; if (q !== 8'h3C) $display("FAIL unmapped_write: got %h exp 3c", q); else passes++;
      rd(DATA_ADDR, q);
      checks++; if (q !== 8'h00) $display("FAIL data_reg_read: got %h exp 00", q); else passes++;
      rd(16'hF202, q);
      checks++; if (q !== 8'hFF) $display("FAIL unmapped_f202: got %h exp ff", q); else passes++;
      rd(16'hF1FF, q);
      checks++; if (q !== 8'hFF) $display("FAIL unmapped_f1ff: got %h exp ff", q); else passes++;
      wr(STAT_ADDR, 8'hFF);
      rd(STAT_ADDR, q);
      checks++; if (q !== 8'h02) $display("FAIL status_write: got %h exp 02", q); else passes++;
   endtask

   task automatic test_tx_frame();
      logic exp_b;
      wr(DATA_ADDR, 8'h41);
      checks++; if (tx !== 1'b1) $display("FAIL frame_pre_tx: got %b exp 1", tx); else passes++;
      checks++; if (tx_busy !== 1'b1) $display("FAIL frame_pre_busy: got %b exp 1", tx_busy); else passes++;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         exp_b = frame_bit(8'h41, k);
         checks++; if (tx !== exp_b) $display("FAIL frame_tx[%0d]: got %b exp %b", k, tx, exp_b); else passes++;
         checks++; if (tx_busy !== 1'b1) $display("FAIL frame_busy[%0d]: got %b exp 1", k, tx_busy); else passes++;
      end
      @(negedge clock);
      checks++; if (tx_busy !== 1'b0) $display("FAIL frame_end_busy: got %b exp 0", tx_busy); else passes++;
      checks++; if (tx !== 1'b1) $display("FAIL frame_end_tx: got %b exp 1", tx); else passes++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [6];
      logic       exp_b;
      bytes = '{8'h11, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      wr(DATA_ADDR, bytes[0]);
      for (int c = 0; c <= 201; c++) begin
         if (c >= 1 && c <= 200) begin
            exp_b = frame_bit(bytes[(c-1)/40], (c-1) % 40);
            checks++; if (tx !== exp_b) $display("FAIL b2b_tx[%0d]: got %b exp %b", c, tx, exp_b); else passes++;
         end
         if (c == 6) begin
            checks++; if (dataInBus !== 8'h84) $display("FAIL b2b_status1: got %h exp 84", dataInBus); else passes++;
         end
         if (c == 7) begin
            checks++; if (dataInBus !== 8'h04) $display("FAIL b2b_status2: got %h exp 04", dataInBus); else passes++;
         end
         if (c == 201) begin
            checks++; if (tx_busy !== 1'b0) $display("FAIL b2b_end_busy: got %b exp 0", tx_busy); else passes++;
            checks++; if (tx !== 1'b1) $display("FAIL b2b_end_tx: got %b exp 1", tx); else passes++;
         end
         writeEnBus = 1'b0; addressBus = IDLE_ADDR;
         if (c <= 4) begin
            writeEnBus = 1'b1; addressBus = DATA_ADDR; dataOutBus = bytes[c+1];
         end else if (c == 5 || c == 6) begin
            addressBus = STAT_ADDR;
         end
         @(negedge clock);
      end
      writeEnBus = 1'b0; addressBus = IDLE_ADDR;
   endtask

   task automatic test_full_pop();
      logic [7:0] bytes [6];
      logic       exp_b;
      bytes = '{8'h20, 8'h31, 8'h42, 8'h53, 8'h64, 8'h75};
      wr(DATA_ADDR, bytes[0]);
      for (int c = 0; c <= 241; c++) begin
         if (c >= 1 && c <= 240) begin
            exp_b = frame_bit(bytes[(c-1)/40], (c-1) % 40);
            checks++; if (tx !== exp_b) $display("FAIL fullpop_tx[%0d]: got %b exp %b", c, tx, exp_b); else passes++;
         end
         if (c == 40) begin
            checks++; if (dataInBus !== 8'h04) $display("FAIL fullpop_status_pre: got %h exp 04", dataInBus); else passes++;
         end
         if (c == 42) begin
            checks++; if (dataInBus !== 8'h04) $display("FAIL fullpop_status_post: got %h exp 04", dataInBus); else passes++;
         end
         if (c == 241) begin
            checks++; if (tx_busy !== 1'b0) $display("FAIL fullpop_end_busy: got %b exp 0", tx_busy); else passes++;
         end
         writeEnBus = 1'b0; addressBus = IDLE_ADDR;
         if (c <= 3) begin
            writeEnBus = 1'b1; addressBus = DATA_ADDR; dataOutBus = bytes[c+1];
         end else if (c == 40) begin
            writeEnBus = 1'b1; addressBus = DATA_ADDR; dataOutBus = bytes[5];
         end else if (c == 39 || c == 41) begin
            addressBus = STAT_ADDR;
         end
         @(negedge clock);
      end
      writeEnBus = 1'b0; addressBus = IDLE_ADDR;
   endtask

   task automatic test_reset_mid_frame();
      wr(DATA_ADDR, 8'h00);
      for (int c = 0; c <= 16; c++) begin
         if (c == 10) begin
            checks++; if (tx !== 1'b0) $display("FAIL midrst_pre_tx: got %b exp 0", tx); else passes++;
            checks++; if (tx_busy !== 1'b1) $display("FAIL midrst_pre_busy: got %b exp 1", tx_busy); else passes++;
         end
         if (c == 11) begin
            checks++; if (tx !== 1'b1) $display("FAIL midrst_tx: got %b exp 1", tx); else passes++;
            checks++; if (tx_busy !== 1'b0) $display("FAIL midrst_busy: got %b exp 0", tx_busy); else passes++;
            checks++; if (dataInBus !== 8'h00) $display("FAIL midrst_data: got %h exp 00", dataInBus); else passes++;
         end
         if (c == 12) begin
            checks++; if (dataInBus !== 8'h02) $display("FAIL midrst_status: got %h exp 02", dataInBus); else passes++;
         end
         if (c == 16) begin
            checks++; if (tx !== 1'b1) $display("FAIL midrst_idle_tx: got %b exp 1", tx); else passes++;
            checks++; if (tx_busy !== 1'b0) $display("FAIL midrst_idle_busy: got %b exp 0", tx_busy); else passes++;
         end
         writeEnBus = 1'b0; addressBus = IDLE_ADDR; reset = 1'b0;
         if (c <= 4) begin
            writeEnBus = 1'b1; addressBus = DATA_ADDR; dataOutBus = 8'h00;
         end else if (c == 10) begin
            reset = 1'b1;
         end else if (c == 11) begin
            addressBus = STAT_ADDR;
         end
         @(negedge clock);
      end
      writeEnBus = 1'b0; addressBus = IDLE_ADDR; reset = 1'b0;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_ram();
      test_decode();
      test_tx_frame();
      test_back_to_back();
      test_full_pop();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
